// File: rtl/motor_step_pulse_generator.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | motor_step_pulse_generator                                                 |
// | Relative move command -> Bresenham-interleaved X/Y step pulse trains.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module motor_step_pulse_generator #(
    parameter int DELTA_BITS         = 12,
    parameter int PULSE_NUM_X_FACTOR = 4,
    parameter int PULSE_NUM_Y_FACTOR = 4,
    parameter int SETTLE_TICKS       = 4,
    parameter int HIGH_TICKS         = 2,
    parameter int LOW_TICKS          = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clk_en,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic signed [DELTA_BITS-1:0] cmd_dx,
    input  logic signed [DELTA_BITS-1:0] cmd_dy,
    input  logic                         cmd_draw,
    output logic                         out_x,
    output logic                         out_y,
    output logic                         dir_x,
    output logic                         dir_y,
    output logic                         should_draw,
    output logic                         busy,
    output logic                         done
);

    localparam int c_PBITS = DELTA_BITS + 8;
    localparam int c_TMAX  = (SETTLE_TICKS > HIGH_TICKS) ?
                             ((SETTLE_TICKS > LOW_TICKS) ? SETTLE_TICKS : LOW_TICKS) :
                             ((HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS);
    localparam int c_CBITS = (c_TMAX > 1) ? $clog2(c_TMAX) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_HIGH   = 2'd2,
        S_LOW    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [c_CBITS-1:0] cnt_q, cnt_d;
    logic [c_PBITS-1:0] rem_q, rem_d;
    logic [c_PBITS-1:0] nmaj_q, nmaj_d;
    logic [c_PBITS-1:0] nmin_q, nmin_d;
    logic [c_PBITS:0]   e_q, e_d;
    logic               major_x_q, major_x_d;
    logic               out_x_q, out_x_d;
    logic               out_y_q, out_y_d;
    logic               dir_x_q, dir_x_d;
    logic               dir_y_q, dir_y_d;
    logic               draw_q, draw_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               ready_q, ready_d;

    logic [DELTA_BITS-1:0] w_abs_dx, w_abs_dy;
    logic [c_PBITS-1:0]    w_nx, w_ny;
    logic [c_PBITS:0]      w_e_sum, w_e_next;
    logic                  w_minor_hit;
    logic                  w_start;

    // |-2^(DELTA_BITS-1)| still fits because the result is treated as unsigned.
    assign w_abs_dx = cmd_dx[DELTA_BITS-1] ? (DELTA_BITS'(0) - cmd_dx) : cmd_dx;
    assign w_abs_dy = cmd_dy[DELTA_BITS-1] ? (DELTA_BITS'(0) - cmd_dy) : cmd_dy;
    assign w_nx     = c_PBITS'(w_abs_dx) * c_PBITS'(PULSE_NUM_X_FACTOR);
    assign w_ny     = c_PBITS'(w_abs_dy) * c_PBITS'(PULSE_NUM_Y_FACTOR);

    assign w_e_sum     = e_q + {1'b0, nmin_q};
    assign w_minor_hit = (w_e_sum >= {1'b0, nmaj_q});
    assign w_e_next    = w_minor_hit ? (w_e_sum - {1'b0, nmaj_q}) : w_e_sum;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        nmaj_d    = nmaj_q;
        nmin_d    = nmin_q;
        e_d       = e_q;
        major_x_d = major_x_q;
        out_x_d   = out_x_q;
        out_y_d   = out_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        draw_d    = draw_q;
        done_d    = 1'b0;
        w_start   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid && ready_q) begin
                    dir_x_d = ~cmd_dx[DELTA_BITS-1];
                    dir_y_d = ~cmd_dy[DELTA_BITS-1];
                    draw_d  = cmd_draw;
                    if (w_nx >= w_ny) begin
                        major_x_d = 1'b1;
                        nmaj_d    = w_nx;
                        nmin_d    = w_ny;
                    end else begin
                        major_x_d = 1'b0;
                        nmaj_d    = w_ny;
                        nmin_d    = w_nx;
                    end
                    rem_d   = nmaj_d;
                    e_d     = {1'b0, nmaj_d >> 1};
                    cnt_d   = '0;
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (clk_en) begin
                    if (cnt_q == c_CBITS'(SETTLE_TICKS - 1)) begin
                        cnt_d = '0;
                        if (rem_q == '0) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            w_start = 1'b1;
                            state_d = S_HIGH;
                        end
                    end else begin
                        cnt_d = cnt_q + c_CBITS'(1);
                    end
                end
            end
            S_HIGH: begin
                if (clk_en) begin
                    if (cnt_q == c_CBITS'(HIGH_TICKS - 1)) begin
                        cnt_d   = '0;
                        out_x_d = 1'b0;
                        out_y_d = 1'b0;
                        state_d = S_LOW;
                    end else begin
                        cnt_d = cnt_q + c_CBITS'(1);
                    end
                end
            end
            S_LOW: begin
                if (clk_en) begin
                    if (cnt_q == c_CBITS'(LOW_TICKS - 1)) begin
                        cnt_d = '0;
                        if (rem_q != '0) begin
                            w_start = 1'b1;
                            state_d = S_HIGH;
                        end else begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        cnt_d = cnt_q + c_CBITS'(1);
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        // The major axis always steps; the minor axis steps when the error overflows.
        if (w_start) begin
            out_x_d = major_x_q ? 1'b1 : w_minor_hit;
            out_y_d = major_x_q ? w_minor_hit : 1'b1;
            e_d     = w_e_next;
            rem_d   = rem_q - c_PBITS'(1);
        end

        busy_d  = (state_d != S_IDLE);
        ready_d = (state_d == S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            nmaj_q    <= '0;
            nmin_q    <= '0;
            e_q       <= '0;
            major_x_q <= 1'b0;
            out_x_q   <= 1'b0;
            out_y_q   <= 1'b0;
            dir_x_q   <= 1'b0;
            dir_y_q   <= 1'b0;
            draw_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            nmaj_q    <= nmaj_d;
            nmin_q    <= nmin_d;
            e_q       <= e_d;
            major_x_q <= major_x_d;
            out_x_q   <= out_x_d;
            out_y_q   <= out_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            draw_q    <= draw_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            ready_q   <= ready_d;
        end
    end

    assign cmd_ready   = ready_q;
    assign out_x       = out_x_q;
    assign out_y       = out_y_q;
    assign dir_x       = dir_x_q;
    assign dir_y       = dir_y_q;
    assign should_draw = draw_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
`default_nettype wire
